// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared state, operation and byte-enable definitions for the data bus bridge
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUS, DONE} bridge_state_t;
  typedef enum logic {OP_READ, OP_WRITE} bus_op_t;
  localparam logic [3:0] BYTEEN_WORD = 4'b1111;
endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: saturating wait-cycle counter with terminal-count flag
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [W-1:0] MAX = '1;
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (enable && count != MAX) count <= count + 1'b1;
  assign terminal = (TIMEOUT_CYCLES > 0) && (count == LAST);
endmodule

// File: rtl/mips_data_bus_bridge.sv
// mips_data_bus_bridge: CPU data port to Avalon-MM master, stalling the CPU via clock enable
module mips_data_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_clk_enable,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_write,
  input  logic        cpu_data_read,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        err_protocol,
  output logic        err_misaligned,
  output logic        err_timeout
);
  bridge_state_t state;
  bus_op_t       op;
  logic          req, req_illegal, tc, abort;
  always_comb begin
    req            = cpu_data_read | cpu_data_write;
    req_illegal    = cpu_data_read & cpu_data_write;
    abort          = tc & avm_waitrequest;
    cpu_clk_enable = ext_clk_enable & ((state == IDLE & (~req | req_illegal)) | state == DONE);
  end
  assign avm_byteenable = BYTEEN_WORD;
  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .enable   (state == BUS && avm_waitrequest),
    .terminal (tc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      op                <= OP_READ;
      avm_read          <= 1'b0;
      avm_write         <= 1'b0;
      avm_address       <= '0;
      avm_writedata     <= '0;
      cpu_data_readdata <= '0;
      err_protocol      <= 1'b0;
      err_misaligned    <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (req_illegal) err_protocol <= 1'b1;
          else if (req && ext_clk_enable) begin
            avm_address   <= {cpu_data_address[31:2], 2'b00};
            avm_writedata <= cpu_data_writedata;
            op            <= cpu_data_write ? OP_WRITE : OP_READ;
            avm_read      <= cpu_data_read;
            avm_write     <= cpu_data_write;
            state         <= BUS;
            if (cpu_data_address[1:0] != 2'b00) err_misaligned <= 1'b1;
          end
        BUS:
          if (!avm_waitrequest || abort) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            state     <= DONE;
            if (op == OP_READ) cpu_data_readdata <= abort ? TIMEOUT_RDATA : avm_readdata;
            if (abort) err_timeout <= 1'b1;
          end
        DONE: if (ext_clk_enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips_data_bus_bridge.md
Name: mips_data_bus_bridge

Overview:
- Sits directly downstream of the CPU's Harvard data port (address / write / read / writedata / readdata).
- Converts the CPU's combinational-read, single-cycle-write data access into an Avalon-MM style master transaction with waitrequest.
- Stalls the CPU by driving its clock-enable low until the bus transaction completes.
- Flags protocol errors, misalignment and bus timeouts for the testbench and for debug.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles waitrequest may stay high before abort; 0 disables the timeout.
- TIMEOUT_RDATA, 32'h0000_0000: value returned to the CPU on a read that times out.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ext_clk_enable  in  1  run enable from the environment; ANDed into cpu_clk_enable
- cpu_data_address  in  32  byte address from the CPU
- cpu_data_write  in  1  CPU write request
- cpu_data_read  in  1  CPU read request
- cpu_data_writedata  in  32  CPU store data
- cpu_data_readdata  out  32  load data returned to the CPU
- cpu_clk_enable  out  1  clock-enable driven into the CPU
- avm_address  out  32  word-aligned bus address
- avm_read  out  1  bus read strobe
- avm_write  out  1  bus write strobe
- avm_writedata  out  32  bus write data
- avm_byteenable  out  4  always 4'b1111
- avm_readdata  in  32  bus read data, valid when avm_read=1 and avm_waitrequest=0
- avm_waitrequest  in  1  slave stall
- err_protocol  out  1  sticky: read and write requested together
- err_misaligned  out  1  sticky: cpu_data_address[1:0] != 0 on a request
- err_timeout  out  1  sticky: a transaction was aborted by the timeout

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: state=IDLE; avm_read=avm_write=0; avm_address=0; avm_writedata=0; cpu_data_readdata=0; all err_* = 0; timeout counter = 0.
- Reset mid-transaction: strobes drop on the next edge with no completion. This is accepted.
- Request definition: req = cpu_data_read | cpu_data_write.
- cpu_clk_enable (combinational) = ext_clk_enable & ((state==IDLE & ~req) | (state==IDLE & req_illegal) | state==DONE).
  - req_illegal = cpu_data_read & cpu_data_write.
  - No combinational path from avm_* inputs to cpu_clk_enable.
- IDLE:
  - Legal request seen and ext_clk_enable=1: latch avm_address = {addr[31:2],2'b00}, avm_writedata, and the operation. Assert avm_read or avm_write from the next cycle. Clear the counter. Go to BUS.
  - Misaligned request: set err_misaligned and still perform the aligned access.
  - Illegal request: set err_protocol, issue no bus access, CPU not stalled; stay in IDLE.
- BUS:
  - Hold avm_address, avm_writedata and the strobe constant.
  - avm_waitrequest=0: on a read, capture avm_readdata into cpu_data_readdata. Deassert the strobe next edge. Go to DONE.
  - avm_waitrequest=1: counter increments.
  - Counter == TIMEOUT_CYCLES-1 with waitrequest still 1 (TIMEOUT_CYCLES != 0): deassert the strobe, set err_timeout, load TIMEOUT_RDATA on a read, go to DONE.
- DONE:
  - cpu_clk_enable=1 for exactly one cycle (if ext_clk_enable=1); the CPU commits the load/store on that edge. Then go to IDLE.
  - If ext_clk_enable=0, remain in DONE until it rises.
- cpu_data_readdata: holds its value until the next completed read.
- Latency: a zero-wait read or write stalls the CPU for 2 cycles (IDLE-detect, BUS) and commits in DONE. Each waitrequest cycle adds 1.
- Back-to-back accesses: after DONE, IDLE re-evaluates the new instruction's request in the same cycle. No idle bubble beyond the FSM.
- Width rules: avm_address[1:0] always 0. avm_byteenable constant 4'b1111. Counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.

Decomposition:
- Package mips_bus_pkg holds:
  - typedef enum logic[1:0] {IDLE, BUS, DONE} bridge_state_t
  - constant BYTEEN_WORD = 4'b1111
  - bus_op_t {OP_READ, OP_WRITE}
- One sub-module: bus_timeout_counter (clear, enable, terminal-count output, TIMEOUT_CYCLES parameter).
- The FSM, latches and error flags stay in mips_data_bus_bridge.

Test Plan:
- Read, zero wait: cpu_data_read=1, addr=0x1000_0004; slave returns 0xCAFEF00D with waitrequest=0 in the first BUS cycle. Required: avm_read high exactly 1 cycle at 0x1000_0004; cpu_clk_enable pattern 0,0,1; cpu_data_readdata=0xCAFEF00D in DONE.
- Write with 3 wait cycles: cpu_data_write=1, addr=0x20, data=0x12345678. Required: avm_write/addr/data stable for 4 cycles; cpu_clk_enable low 5 cycles, then high 1.
- Misaligned read: addr=0x0000_0103. Required: avm_address=0x0000_0100; err_misaligned=1 and stays 1; transaction completes normally.
- Timeout: TIMEOUT_CYCLES=8, waitrequest held 1, read. Required: avm_read drops after 8 BUS cycles; err_timeout=1; cpu_data_readdata=TIMEOUT_RDATA; CPU released one cycle later.
- Illegal request plus back-to-back: read and write both asserted. Required: no avm strobe, err_protocol=1, cpu_clk_enable=1. Then two consecutive zero-wait loads. Required: two separate bus reads with no lost or duplicated access.
- Reset mid-BUS: assert reset during a waitrequest stall. Required: on the next edge avm_read=0, state=IDLE, err_* cleared, cpu_clk_enable follows the IDLE rule.
